// File: rtl/plab2_proc_mem_port_arb.sv
// plab2_proc_mem_port_arb
//   Merges the processor imem/dmem request ports onto one memory port and
//   routes the in-order memory responses back to the issuing port. Outgoing
//   opaques are replaced by a tag-FIFO write pointer. The original opaque is
//   restored on the response. Requests from different security domains are
//   never in flight together.
//   Message layouts (MSB..LSB):
//     req  = {type[2:0], opaque, addr, len, data}
//     resp = {type[2:0], opaque, test[1:0], len, data}
//   Optional build macro PLAB2_PROC_MEM_ARB_STATS_EN adds the per-port grant
//   counters imem_grants / dmem_grants.
module plab2_proc_mem_port_arb #(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_num_outstand = 4,
  localparam int LEN_NB  = $clog2(p_data_nbits/8),
  localparam int REQ_NB  = 3 + p_opaque_nbits + p_addr_nbits + LEN_NB + p_data_nbits,
  localparam int RESP_NB = 3 + p_opaque_nbits + 2 + LEN_NB + p_data_nbits
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               domain,
  input  logic [REQ_NB-1:0]  imemreq_msg,
  input  logic               imemreq_val,
  output logic               imemreq_rdy,
  output logic [RESP_NB-1:0] imemresp_msg,
  output logic               imemresp_val,
  input  logic               imemresp_rdy,
  input  logic [REQ_NB-1:0]  dmemreq_msg,
  input  logic               dmemreq_val,
  output logic               dmemreq_rdy,
  output logic [RESP_NB-1:0] dmemresp_msg,
  output logic               dmemresp_val,
  input  logic               dmemresp_rdy,
  output logic [REQ_NB-1:0]  memreq_msg,
  output logic               memreq_val,
  input  logic               memreq_rdy,
  input  logic [RESP_NB-1:0] memresp_msg,
  input  logic               memresp_val,
  output logic               memresp_rdy,
  output logic               busy,
`ifdef PLAB2_PROC_MEM_ARB_STATS_EN
  output logic [31:0]        imem_grants,
  output logic [31:0]        dmem_grants,
`endif
  output logic               err
);

  localparam int PTR_NB     = $clog2(p_num_outstand);
  localparam int REQ_OP_LSB = p_addr_nbits + LEN_NB + p_data_nbits;
  localparam int RSP_OP_LSB = 2 + LEN_NB + p_data_nbits;
  localparam logic [PTR_NB:0] FULL = (PTR_NB+1)'(p_num_outstand);

  typedef struct packed {
    logic                      port;  // 0 = imem, 1 = dmem
    logic [p_opaque_nbits-1:0] op;    // opaque supplied by the processor
  } tag_t;

  tag_t                tags [p_num_outstand];
  logic [PTR_NB-1:0]   wr_ptr, rd_ptr;
  logic [PTR_NB:0]     count;
  logic                rr_ptr;   // preferred port: 0 = imem, 1 = dmem
  logic                dom_q;
  logic                err_q;

  logic                grant_d, gnt_val, legal, dom_block, push, pop, empty;
  logic [REQ_NB-1:0]   gnt_msg;
  tag_t                head;

  assign empty     = (count == '0);
  assign dom_block = !empty && (domain != dom_q);
  assign legal     = (count < FULL) && !dom_block;
  assign head      = tags[rd_ptr];

  // Round-robin grant: dmem wins only when imem is idle or it is dmem's turn.
  always_comb begin
    grant_d     = dmemreq_val && (!imemreq_val || rr_ptr);
    gnt_val     = grant_d ? dmemreq_val : imemreq_val;
    gnt_msg     = grant_d ? dmemreq_msg : imemreq_msg;
    memreq_val  = gnt_val && legal;
    imemreq_rdy = !grant_d && memreq_rdy && legal;
    dmemreq_rdy =  grant_d && memreq_rdy && legal;
    memreq_msg  = gnt_msg;
    memreq_msg[REQ_OP_LSB +: p_opaque_nbits] = p_opaque_nbits'(wr_ptr);
  end

  // Response steering to the port recorded at the FIFO head; with nothing
  // outstanding the response is sunk and flagged.
  always_comb begin
    imemresp_msg = memresp_msg;
    imemresp_msg[RSP_OP_LSB +: p_opaque_nbits] = head.op;
    dmemresp_msg = imemresp_msg;
    imemresp_val = 1'b0;
    dmemresp_val = 1'b0;
    memresp_rdy  = 1'b1;
    if (!empty) begin
      memresp_rdy  = head.port ? dmemresp_rdy : imemresp_rdy;
      imemresp_val = memresp_val && !head.port;
      dmemresp_val = memresp_val &&  head.port;
    end
  end

  assign push = memreq_val && memreq_rdy;
  assign pop  = !empty && memresp_val && memresp_rdy;
  assign busy = !empty;
  assign err  = err_q;

  // Tag storage: no reset needed, entries are only read while valid.
  always_ff @(posedge clk) begin
    if (push) tags[wr_ptr] <= '{port: grant_d, op: gnt_msg[REQ_OP_LSB +: p_opaque_nbits]};
  end

  // Pointers, occupancy, round-robin, domain latch and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= 1'b0;
      dom_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= !grant_d;
        dom_q  <= domain;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_NB+1)'(push) - (PTR_NB+1)'(pop);
      if ((memresp_val && empty) ||
          (pop && memresp_msg[RSP_OP_LSB +: p_opaque_nbits] != p_opaque_nbits'(rd_ptr)))
        err_q <= 1'b1;
    end
  end

`ifdef PLAB2_PROC_MEM_ARB_STATS_EN
  // Per-port accepted-request counters, free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_grants <= '0;
      dmem_grants <= '0;
    end else if (push) begin
      if (grant_d) dmem_grants <= dmem_grants + 32'd1;
      else         imem_grants <= imem_grants + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_plab2_proc_mem_port_arb.sv
// tb_plab2_proc_mem_port_arb
//   Table-driven cycle vectors for arbitration, tagging, domain stall and
//   error flag, plus hand sequences for streaming, FIFO-full and reset.
module tb_plab2_proc_mem_port_arb;

  localparam int REQ_NB  = 77;
  localparam int RESP_NB = 47;

  logic clk = 1'b0;
  logic reset, domain;
  logic [REQ_NB-1:0]  imemreq_msg, dmemreq_msg, memreq_msg;
  logic [RESP_NB-1:0] imemresp_msg, dmemresp_msg, memresp_msg;
  logic imemreq_val, imemreq_rdy, imemresp_val, imemresp_rdy;
  logic dmemreq_val, dmemreq_rdy, dmemresp_val, dmemresp_rdy;
  logic memreq_val, memreq_rdy, memresp_val, memresp_rdy, busy, err;
`ifdef PLAB2_PROC_MEM_ARB_STATS_EN
  logic [31:0] imem_grants, dmem_grants;
`endif

  plab2_proc_mem_port_arb dut (
    .clk(clk), .reset(reset), .domain(domain),
    .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy),
    .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
    .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .busy(busy),
`ifdef PLAB2_PROC_MEM_ARB_STATS_EN
    .imem_grants(imem_grants), .dmem_grants(dmem_grants),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [REQ_NB-1:0] mk_req(input logic [7:0] op, input logic [31:0] addr);
    return {3'd0, op, addr, 2'd0, 32'd0};
  endfunction

  function automatic logic [RESP_NB-1:0] mk_resp(input logic [7:0] op, input logic [31:0] d);
    return {3'd0, op, 2'd0, 2'd0, d};
  endfunction

  typedef struct {
    logic rst, dom, iv, dv, mrdy, mrv; logic [7:0] mrop; logic irr, drr;
    logic e_mv, e_ir, e_dr; logic [7:0] e_mop;
    logic e_iv, e_dv, e_mrr, e_busy, e_err; logic [7:0] e_rop;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, dom, iv, dv, mrdy, mrv, input logic [7:0] mrop, input logic irr, drr,
    input logic e_mv, e_ir, e_dr, input logic [7:0] e_mop,
    input logic e_iv, e_dv, e_mrr, e_busy, e_err, input logic [7:0] e_rop);
    vec_t v;
    v.rst = rst; v.dom = dom; v.iv = iv; v.dv = dv; v.mrdy = mrdy; v.mrv = mrv;
    v.mrop = mrop; v.irr = irr; v.drr = drr; v.e_mv = e_mv; v.e_ir = e_ir; v.e_dr = e_dr;
    v.e_mop = e_mop; v.e_iv = e_iv; v.e_dv = e_dv; v.e_mrr = e_mrr; v.e_busy = e_busy;
    v.e_err = e_err; v.e_rop = e_rop;
    return v;
  endfunction

  task automatic idle_inputs();
    domain = 0; imemreq_val = 0; dmemreq_val = 0; memreq_rdy = 0; memresp_val = 0;
    imemresp_rdy = 0; dmemresp_rdy = 0;
    imemreq_msg = mk_req(8'h11, 32'h100); dmemreq_msg = mk_req(8'h22, 32'h200);
    memresp_msg = mk_resp(8'h00, 32'h0);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  typedef struct { logic [7:0] op; logic [31:0] d; } mr_t;

  // Streams requests through a 1-cycle echo memory and scoreboards responses.
  task automatic run_stream(input bit use_d, input int n_i, input int n_d, input logic [7:0] ibase);
    mr_t mq[$]; mr_t nq[$]; int ep[$]; logic [7:0] eo[$]; logic [31:0] ea[$];
    int si = 0, sd = 0, got = 0, ngrant = 0, cyc = 0, wr_model = 0;
    bit saw_d = 0;
    while (got < n_i + n_d && cyc < 200) begin
      imemreq_val  = (si < n_i);
      dmemreq_val  = use_d && (sd < n_d);
      imemreq_msg  = mk_req(ibase + 8'(si), 32'h1000 + 32'(si*4));
      dmemreq_msg  = mk_req(8'h80 + 8'(sd), 32'h2000 + 32'(sd*4));
      memresp_val  = (mq.size() != 0);
      memresp_msg  = mk_resp(mq.size() != 0 ? mq[0].op : 8'h0, mq.size() != 0 ? mq[0].d : 32'h0);
      memreq_rdy   = 1; imemresp_rdy = 1; dmemresp_rdy = 1;
      #1;
      nq = {};
      if (memreq_val && memreq_rdy) begin
        chk("stream_req_tag", 32'(memreq_msg[73:66]), 32'(wr_model % 4));
        wr_model++;
        nq.push_back('{op: memreq_msg[73:66], d: memreq_msg[65:34]});
      end
      if (imemreq_val && imemreq_rdy) begin
        if (use_d) chk("alt_grant_i", 32'(ngrant % 2), 32'd0);
        ep.push_back(0); eo.push_back(ibase + 8'(si)); ea.push_back(32'h1000 + 32'(si*4));
        si++; ngrant++;
      end else if (dmemreq_val && dmemreq_rdy) begin
        chk("alt_grant_d", 32'(ngrant % 2), 32'd1);
        ep.push_back(1); eo.push_back(8'h80 + 8'(sd)); ea.push_back(32'h2000 + 32'(sd*4));
        sd++; ngrant++;
      end
      if (dmemresp_val) saw_d = 1;
      if (imemresp_val || dmemresp_val) begin
        if (ep.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
        else begin
          chk("resp_port", {31'd0, dmemresp_val}, 32'(ep[0]));
          chk("resp_opaque", 32'(dmemresp_val ? dmemresp_msg[43:36] : imemresp_msg[43:36]), 32'(eo[0]));
          chk("resp_data", dmemresp_val ? dmemresp_msg[31:0] : imemresp_msg[31:0], ea[0]);
          void'(ep.pop_front()); void'(eo.pop_front()); void'(ea.pop_front());
          got++;
        end
      end
      if (memresp_val && memresp_rdy) void'(mq.pop_front());
      @(posedge clk); #1;
      foreach (nq[k]) mq.push_back(nq[k]);
      cyc++;
    end
    chk("stream_resp_count", 32'(got), 32'(n_i + n_d));
    if (!use_d) chk("stream_no_dmemresp", {31'd0, saw_d}, 32'd0);
    chk("stream_err", {31'd0, err}, 32'd0);
    idle_inputs();
  endtask

  vec_t vt [18];

  initial begin
    int acc;
    //            rst dom iv dv mrdy mrv mrop irr drr | mv ir dr mop   iv dv mrr busy err rop
    vt[0]  = mk(1, 0, 0, 0, 0, 0, 8'd0, 0, 0,  0, 0, 0, 8'd0,  0, 0, 1, 0, 0, 8'h00);
    vt[1]  = mk(0, 0, 1, 1, 1, 0, 8'd0, 0, 0,  1, 1, 0, 8'd0,  0, 0, 1, 0, 0, 8'h00);
    vt[2]  = mk(0, 0, 1, 1, 1, 1, 8'd0, 1, 1,  1, 0, 1, 8'd1,  1, 0, 1, 1, 0, 8'h11);
    vt[3]  = mk(0, 0, 0, 1, 0, 1, 8'd1, 1, 0,  1, 0, 0, 8'd2,  0, 1, 0, 1, 0, 8'h22);
    vt[4]  = mk(0, 0, 0, 1, 0, 1, 8'd1, 1, 1,  1, 0, 0, 8'd2,  0, 1, 1, 1, 0, 8'h22);
    vt[5]  = mk(0, 0, 1, 0, 1, 0, 8'd0, 0, 0,  1, 1, 0, 8'd2,  0, 0, 1, 0, 0, 8'h00);
    vt[6]  = mk(0, 1, 1, 0, 1, 0, 8'd0, 1, 0,  0, 0, 0, 8'd0,  0, 0, 1, 1, 0, 8'h00);
    vt[7]  = mk(0, 1, 1, 0, 1, 1, 8'd2, 1, 0,  0, 0, 0, 8'd0,  1, 0, 1, 1, 0, 8'h11);
    vt[8]  = mk(0, 1, 1, 0, 1, 0, 8'd0, 0, 0,  1, 1, 0, 8'd3,  0, 0, 1, 0, 0, 8'h00);
    vt[9]  = mk(0, 1, 0, 0, 0, 1, 8'd5, 1, 0,  0, 0, 0, 8'd0,  1, 0, 1, 1, 0, 8'h11);
    vt[10] = mk(0, 1, 0, 0, 0, 0, 8'd0, 0, 0,  0, 0, 0, 8'd0,  0, 0, 1, 0, 1, 8'h00);
    vt[11] = mk(0, 1, 0, 0, 0, 1, 8'd0, 0, 0,  0, 0, 0, 8'd0,  0, 0, 1, 0, 1, 8'h00);
    vt[12] = mk(1, 0, 0, 0, 0, 0, 8'd0, 0, 0,  0, 0, 0, 8'd0,  0, 0, 1, 0, 1, 8'h00);
    vt[13] = mk(0, 0, 0, 0, 0, 0, 8'd0, 0, 0,  0, 0, 0, 8'd0,  0, 0, 1, 0, 0, 8'h00);
    vt[14] = mk(0, 0, 0, 0, 0, 1, 8'd0, 0, 0,  0, 0, 0, 8'd0,  0, 0, 1, 0, 0, 8'h00);
    vt[15] = mk(0, 0, 0, 0, 0, 0, 8'd0, 0, 0,  0, 0, 0, 8'd0,  0, 0, 1, 0, 1, 8'h00);
    vt[16] = mk(1, 0, 0, 0, 0, 0, 8'd0, 0, 0,  0, 0, 0, 8'd0,  0, 0, 1, 0, 1, 8'h00);
    vt[17] = mk(0, 0, 0, 0, 0, 0, 8'd0, 0, 0,  0, 0, 0, 8'd0,  0, 0, 1, 0, 0, 8'h00);

    do_reset();

    // Vector table: inputs applied after the edge, outputs checked 1ns later.
    for (int i = 0; i < 18; i++) begin
      reset = vt[i].rst; domain = vt[i].dom;
      imemreq_val = vt[i].iv; dmemreq_val = vt[i].dv; memreq_rdy = vt[i].mrdy;
      memresp_val = vt[i].mrv; memresp_msg = mk_resp(vt[i].mrop, 32'hABCD);
      imemresp_rdy = vt[i].irr; dmemresp_rdy = vt[i].drr;
      imemreq_msg = mk_req(8'h11, 32'h100); dmemreq_msg = mk_req(8'h22, 32'h200);
      #1;
      chk($sformatf("v%0d_memreq_val", i), {31'd0, memreq_val}, {31'd0, vt[i].e_mv});
      chk($sformatf("v%0d_imemreq_rdy", i), {31'd0, imemreq_rdy}, {31'd0, vt[i].e_ir});
      chk($sformatf("v%0d_dmemreq_rdy", i), {31'd0, dmemreq_rdy}, {31'd0, vt[i].e_dr});
      chk($sformatf("v%0d_imemresp_val", i), {31'd0, imemresp_val}, {31'd0, vt[i].e_iv});
      chk($sformatf("v%0d_dmemresp_val", i), {31'd0, dmemresp_val}, {31'd0, vt[i].e_dv});
      chk($sformatf("v%0d_memresp_rdy", i), {31'd0, memresp_rdy}, {31'd0, vt[i].e_mrr});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].e_busy});
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vt[i].e_err});
      if (vt[i].e_mv)
        chk($sformatf("v%0d_memreq_opaque", i), 32'(memreq_msg[73:66]), 32'(vt[i].e_mop));
      if (vt[i].e_iv)
        chk($sformatf("v%0d_imemresp_opaque", i), 32'(imemresp_msg[43:36]), 32'(vt[i].e_rop));
      if (vt[i].e_dv)
        chk($sformatf("v%0d_dmemresp_opaque", i), 32'(dmemresp_msg[43:36]), 32'(vt[i].e_rop));
      @(posedge clk); #1;
    end

    // imem-only stream of 8 reads, original opaque 0.
    do_reset();
    run_stream(1'b0, 8, 0, 8'h00);

    // Both ports valid every cycle: grants alternate I,D,I,D.
    do_reset();
    run_stream(1'b1, 4, 4, 8'h40);

    // Fill to capacity, then a pop in the same cycle as a blocked enqueue.
    do_reset();
    imemreq_val = 1; memreq_rdy = 1; imemreq_msg = mk_req(8'h00, 32'h300);
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c >= 4) chk($sformatf("fill_rdy_low_c%0d", c), {31'd0, imemreq_rdy}, 32'd0);
      if (imemreq_val && imemreq_rdy) acc++;
      @(posedge clk); #1;
    end
    chk("fill_accepted", 32'(acc), 32'd4);
    chk("fill_busy", {31'd0, busy}, 32'd1);
    memresp_val = 1; memresp_msg = mk_resp(8'h00, 32'h0); imemresp_rdy = 1;
    #1;
    chk("full_pop_cycle_rdy", {31'd0, imemreq_rdy}, 32'd0);
    chk("full_pop_resp_val", {31'd0, imemresp_val}, 32'd1);
    @(posedge clk); #1;
    memresp_val = 0;
    #1;
    chk("refill_rdy", {31'd0, imemreq_rdy}, 32'd1);
    chk("refill_val", {31'd0, memreq_val}, 32'd1);
    @(posedge clk); #1;
    chk("refill_then_full", {31'd0, imemreq_rdy}, 32'd0);
    chk("fill_err", {31'd0, err}, 32'd0);

    // Reset with 3 outstanding, then a stale response.
    do_reset();
    imemreq_val = 1; memreq_rdy = 1;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
    imemreq_val = 0;
    #1;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
`ifdef PLAB2_PROC_MEM_ARB_STATS_EN
    chk("pre_reset_imem_grants", imem_grants, 32'd3);
    chk("pre_reset_dmem_grants", dmem_grants, 32'd0);
`endif
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    #1;
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("post_reset_err", {31'd0, err}, 32'd0);
    chk("post_reset_memreq_val", {31'd0, memreq_val}, 32'd0);
`ifdef PLAB2_PROC_MEM_ARB_STATS_EN
    chk("post_reset_imem_grants", imem_grants, 32'd0);
    chk("post_reset_dmem_grants", dmem_grants, 32'd0);
`endif
    memresp_val = 1; memresp_msg = mk_resp(8'h00, 32'h0); imemresp_rdy = 1;
    #1;
    chk("stale_resp_rdy", {31'd0, memresp_rdy}, 32'd1);
    chk("stale_resp_not_routed", {31'd0, imemresp_val}, 32'd0);
    @(posedge clk); #1;
    memresp_val = 0;
    chk("stale_resp_err", {31'd0, err}, 32'd1);
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
    chk("stale_err_held", {31'd0, err}, 32'd1);
    do_reset();
    #1;
    chk("final_err_clear", {31'd0, err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
